fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of FIFO memory read data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width (depth 2^ADDR_WIDTH); pointers are ADDR_WIDTH+1 bits.
REQ-003 SHALL have port clk  input  1  read-domain clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-low (0 = reset).
REQ-005 SHALL have port wptr_gray_sync  input  ADDR_WIDTH+1  write pointer, Gray coded, already passed through two-flop synchronizer into clk domain.
REQ-006 SHALL have port rptr_gray  output  ADDR_WIDTH+1  registered read pointer, Gray coded, for write-domain synchronizer.
REQ-007 SHALL have port mem_ren  output  1  memory read strobe.
REQ-008 SHALL have port mem_raddr  output  ADDR_WIDTH  memory read address.
REQ-009 SHALL have port mem_rdata  input  DATA_WIDTH  memory data, valid exactly one cycle after mem_ren.
REQ-010 SHALL have port dout  output  DATA_WIDTH  registered output word.
REQ-011 SHALL have port dout_valid  output  1  dout holds a word.
REQ-012 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-013 SHALL have port empty  output  1  no word in memory and none held.

Function
REQ-014 SHALL keep read pointer rptr_bin (ADDR_WIDTH+1 bits, binary), wrapping 2^(ADDR_WIDTH+1)-1 -> 0; rptr_gray SHALL equal rptr_bin ^ (rptr_bin >> 1), both registered.
REQ-015 SHALL define mem_empty = (rptr_gray == wptr_gray_sync); mem_raddr = rptr_bin[ADDR_WIDTH-1:0].
REQ-016 SHALL implement FSM states IDLE, FETCH, VALID.
REQ-017 IDLE: dout_valid=0; if !mem_empty assert mem_ren (combinational), increment rptr_bin, go FETCH; else stay.
REQ-018 FETCH: mem_ren=0; at clock edge load dout <= mem_rdata, go VALID.
REQ-019 VALID: dout_valid=1; dout held stable while dout_ready=0.
REQ-020 VALID with dout_ready=1: if !mem_empty assert mem_ren, increment rptr_bin, go FETCH; else go IDLE.
REQ-021 Throughput SHALL be at most one word per two cycles; first-word latency from mem_empty falling in IDLE to dout_valid=1 SHALL be 2 cycles.
REQ-022 mem_ren SHALL never assert while mem_empty=1 or in FETCH; rptr_bin changes only on mem_ren.
REQ-023 empty SHALL be 1 exactly when state==IDLE and mem_empty=1.
REQ-024 wptr_gray_sync changing in the same cycle as mem_ren SHALL take effect on mem_empty next cycle; no read is lost or duplicated.
REQ-025 dout_ready while dout_valid=0 SHALL be ignored.

Reset
REQ-026 With rst=0 at a clock edge: rptr_bin=0, rptr_gray=0, state=IDLE, dout=0, dout_valid=0; mem_ren SHALL be 0 while rst=0.
REQ-027 Reset in FETCH or VALID SHALL discard the pending/held word; no mem_ren in the first cycle after rst returns to 1.

Configuration
REQ-028 Macro FIFO_RD_LEVEL_EN SHALL control an occupancy output.
REQ-029 Defined: add port rd_level  output  ADDR_WIDTH+1, registered, = (gray2bin(wptr_gray_sync) - rptr_bin) mod 2^(ADDR_WIDTH+1), reset to 0; range 0..2^ADDR_WIDTH.
REQ-030 Not defined: rd_level port and Gray-to-binary logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset then wptr_gray_sync=0 held 10 cycles -> empty=1, mem_ren=0, rptr_gray=0, dout_valid=0.
REQ-032 wptr_gray_sync 0->1, dout_ready=1 -> mem_ren cycle 0 with mem_raddr=0, dout_valid=1 cycle 2 with dout=mem_rdata, rptr_gray=1, then IDLE, empty=1.
REQ-033 Write 3 words, dout_ready=0 for 5 cycles -> dout stable, dout_valid=1, single mem_ren; ready=1 -> remaining two words delivered in order, 2 cycles apart.
REQ-034 ADDR_WIDTH=4, stream 40 words -> rptr_bin wraps 31->0, rptr_gray 5'b10000 -> 5'b00000, no lost/duplicate data.
REQ-035 rst=0 asserted in FETCH -> next cycle dout_valid=0, rptr_gray=0, state IDLE.
REQ-036 FIFO_RD_LEVEL_EN defined, 16 words written, none read -> rd_level=16; after one read rd_level=15.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_ctrl: async-FIFO read-side controller (Gray read pointer,        |
// | single-word prefetch FSM, registered output). FIFO_RD_LEVEL_EN: rd_level.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR_WIDTH:0]   rd_level,
`endif
  output logic                  empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_WIDTH:0] rptr_bin;
  logic [ADDR_WIDTH:0] rptr_bin_nxt;
  logic                mem_empty;
  logic                started;

  assign mem_empty    = (rptr_gray == wptr_gray_sync);
  assign rptr_bin_nxt = rptr_bin + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign mem_raddr    = rptr_bin[ADDR_WIDTH-1:0];
  assign dout_valid   = (state == VALID);
  assign empty        = (state == IDLE) && mem_empty;

  always_comb begin
    state_nxt = state;
    mem_ren   = 1'b0;
    case (state)
      // started blocks a read in the first cycle after reset release
      IDLE: begin
        if (!mem_empty && started) begin
          mem_ren   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = VALID;
      VALID: begin
        if (dout_ready) begin
          if (!mem_empty) begin
            mem_ren   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      mem_ren   = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rptr_bin  <= '0;
      rptr_gray <= '0;
      dout      <= '0;
      started   <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (mem_ren) begin
        rptr_bin  <= rptr_bin_nxt;
        rptr_gray <= rptr_bin_nxt ^ (rptr_bin_nxt >> 1);
      end
      if (state == FETCH) begin
        dout <= mem_rdata;
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= gray2bin(wptr_gray_sync) - rptr_bin;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_ctrl: self-checking bench for fifo_rd_ctrl.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NROWS = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW:0]   wptr_gray_sync = '0;
  logic [AW:0]   rptr_gray;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0]   rd_level;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] sb_q [$];
  int   wr_cnt = 0;
  int   acc_cnt = 0;
  int   ren_cnt = 0;
  int   cyc = 0;
  int   prev_acc = 0;
  logic sb_en = 1'b0;
  logic gap_en = 1'b0;
  logic have_prev = 1'b0;
  logic saw_wrap = 1'b0;
  logic [AW:0] prev_gray = '0;

  typedef struct {
    logic          rst;
    logic [AW:0]   wg;
    logic          rdy;
    logic          ren;
    logic [AW-1:0] raddr;
    logic          valid;
    logic          emp;
    logic [AW:0]   rg;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t tbl [NROWS];

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wptr_gray_sync (wptr_gray_sync),
    .rptr_gray      (rptr_gray),
    .mem_ren        (mem_ren),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
`ifdef FIFO_RD_LEVEL_EN
    .rd_level       (rd_level),
`endif
    .empty          (empty)
  );

  always #5 clk = ~clk;

  // Memory returns data one cycle after the read strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ren) mem_rdata <= mem_model[mem_raddr];
  end

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem_model[wr_cnt[AW-1:0]] = d;
    sb_q.push_back(d);
    wr_cnt++;
    wptr_gray_sync = gray(wr_cnt);
  endtask

  // Sample one cycle's outputs, score accepted words, advance to next negedge
  task automatic step();
    #1;
    if (mem_ren) begin
      ren_cnt++;
      chk("ren_while_mem_empty", {31'd0, rptr_gray == wptr_gray_sync}, 32'd0);
    end
    if (prev_gray == 5'b10000 && rptr_gray == 5'b00000) saw_wrap = 1'b1;
    prev_gray = rptr_gray;
    if (sb_en && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_word: got %0h expected none", dout);
      end else begin
        chk("sb_data", dout, sb_q.pop_front());
      end
      if (gap_en && have_prev) chk("accept_gap", cyc - prev_acc, 2);
      have_prev = 1'b1;
      prev_acc  = cyc;
      acc_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ren0;
    int target;
    for (int i = 0; i < (1 << AW); i++) mem_model[i] = '0;
    mem_model[0] = 8'hA5;

    // rst, wg, rdy | ren, raddr, valid, empty, rptr_gray, dout
    tbl[0] = '{1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 5'd0, 8'h00};
    for (int i = 1; i <= 10; i++)
      tbl[i] = '{1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 5'd0, 8'h00};
    tbl[11] = '{1'b1, 5'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 5'd0, 8'h00};
    tbl[12] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 5'd1, 8'h00};
    tbl[13] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 5'd1, 8'hA5};
    tbl[14] = '{1'b1, 5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 5'd1, 8'hA5};

    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NROWS; i++) begin
      rst            = tbl[i].rst;
      wptr_gray_sync = tbl[i].wg;
      dout_ready     = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d mem_ren", i),    mem_ren,    tbl[i].ren);
      chk($sformatf("row%0d mem_raddr", i),  mem_raddr,  tbl[i].raddr);
      chk($sformatf("row%0d dout_valid", i), dout_valid, tbl[i].valid);
      chk($sformatf("row%0d empty", i),      empty,      tbl[i].emp);
      chk($sformatf("row%0d rptr_gray", i),  rptr_gray,  tbl[i].rg);
      chk($sformatf("row%0d dout", i),       dout,       tbl[i].dout);
      @(negedge clk);
    end
    wr_cnt  = 1;
    acc_cnt = 1;

    // Three words, consumer stalled, then released
    sb_en      = 1'b1;
    dout_ready = 1'b0;
    ren0       = ren_cnt;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", dout_valid, 1);
      chk("stall_dout", dout, 8'h11);
      step();
    end
    chk("stall_single_ren", ren_cnt - ren0, 1);
    dout_ready = 1'b1;
    gap_en     = 1'b1;
    have_prev  = 1'b0;
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
    gap_en = 1'b0;
    chk("stall_drain_left", sb_q.size(), 0);
    step();
    chk("stall_empty_after", empty, 1);

    // Long random stream crossing the pointer wrap
    target = wr_cnt + 40;
    for (int t = 0; t < 2000 && acc_cnt < target; t++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if (wr_cnt < target && (wr_cnt - acc_cnt) < 15 && $urandom_range(0, 1) == 1)
        write_word(DW'($urandom));
      step();
    end
    dout_ready = 1'b1;
    chk("stream_count", acc_cnt, target);
    chk("stream_left", sb_q.size(), 0);
    chk("stream_wrap_seen", saw_wrap, 1);
    step();
    step();
    chk("stream_rptr_gray", rptr_gray, gray(wr_cnt));
    chk("stream_empty", empty, 1);

    // Reset while a fetch is in flight
    write_word(8'hC3);
    step();
    #1;
    chk("fetch_no_ren", mem_ren, 0);
    chk("fetch_not_valid", dout_valid, 0);
    rst = 1'b0;
    sb_en = 1'b0;
    sb_q.delete();
    wr_cnt = 0;
    acc_cnt = 0;
    wptr_gray_sync = '0;
    @(negedge clk);
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_rptr_gray", rptr_gray, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dout", dout, 0);
    write_word(8'h5A);
    #1;
    chk("rst_no_ren", mem_ren, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_no_ren", mem_ren, 0);
    @(negedge clk);
    #1;
    chk("release_ren_next", mem_ren, 1);
    chk("release_raddr", mem_raddr, 0);
    sb_en = 1'b1;
    have_prev = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 10 && acc_cnt < 1; t++) step();
    chk("release_delivered", acc_cnt, 1);

`ifdef FIFO_RD_LEVEL_EN
    rst = 1'b0;
    sb_en = 1'b0;
    dout_ready = 1'b0;
    wr_cnt = 0;
    wptr_gray_sync = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("level_reset", rd_level, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) write_word(DW'(i));
    sb_q.delete();
    @(negedge clk);
    #1;
    chk("level_full", rd_level, 16);
    @(negedge clk);
    #1;
    chk("level_after_read", rd_level, 15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
